// File: rtl/onehot_scanner.sv
// onehot_scanner: walks a one-hot select line across LENGTH outputs and skips
// masked lines. A scan starts from bit 0 (dir=0) or bit LENGTH-1 (dir=1) and
// steps toward the far end. At the far end the scan either finishes, or wraps
// when WRAP=1.
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start/step      begin a scan (IDLE only) / advance one unmasked line (SCAN only)
//   dir             scan direction, latched on an accepted start
//   abort/load      return to IDLE / force the line to load_idx (priority abort > load > start > step)
//   skip_mask       bit i = 1 excludes line i; sampled live
//   output_enable   out = position when 1, high-impedance when 0
//   out, index      select lines and binary index of the active line
//   busy/done/wrapped  in SCAN / one-cycle finish pulse / one-cycle wrap pulse
module onehot_scanner #(
   parameter int LENGTH = 4,
   parameter int WRAP   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      step,
   input  logic                      dir,
   input  logic                      abort,
   input  logic                      load,
   input  logic [$clog2(LENGTH)-1:0] load_idx,
   input  logic [LENGTH-1:0]         skip_mask,
   input  logic                      output_enable,
   output logic [LENGTH-1:0]         out,
   output logic [$clog2(LENGTH)-1:0] index,
   output logic                      busy,
   output logic                      done,
   output logic                      wrapped
);
   localparam int          IW    = $clog2(LENGTH);
   localparam int unsigned LEN_U = LENGTH;
   localparam int unsigned SPAN  = 1 << IW;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state;
   logic [LENGTH-1:0] position;
   logic              dir_q;

   logic              lo_ok, hi_ok, up_ok, dn_ok;
   logic [IW-1:0]     lo_idx, hi_idx, up_idx, dn_idx;
   logic [SPAN-1:0]   idx_valid;
   logic              load_ok;
   logic              first_ok, beyond_ok, wrap_ok;
   logic [IW-1:0]     first_idx, beyond_idx, wrap_idx;

   function automatic logic [LENGTH-1:0] one_hot(input logic [IW-1:0] i);
      return {{(LENGTH-1){1'b0}}, 1'b1} << i;
   endfunction

   assign out = output_enable ? position : 'z;

   always_comb begin
      index = '0;
      for (int unsigned i = 0; i < LEN_U; i++)
         if (position[i]) index = index | IW'(i);
   end

   // One pass over the mask collects the lowest and highest unmasked lines,
   // and the nearest unmasked lines above and below the current one.
   always_comb begin
      lo_ok  = 1'b0;
      hi_ok  = 1'b0;
      up_ok  = 1'b0;
      dn_ok  = 1'b0;
      lo_idx = '0;
      hi_idx = '0;
      up_idx = '0;
      dn_idx = '0;
      for (int unsigned i = 0; i < LEN_U; i++) begin
         if (!skip_mask[i]) begin
            if (!lo_ok) begin
               lo_ok  = 1'b1;
               lo_idx = IW'(i);
            end
            hi_ok  = 1'b1;
            hi_idx = IW'(i);
            if (IW'(i) > index && !up_ok) begin
               up_ok  = 1'b1;
               up_idx = IW'(i);
            end
            if (IW'(i) < index) begin
               dn_ok  = 1'b1;
               dn_idx = IW'(i);
            end
         end
      end
   end

   // Indices at or above LENGTH exist only when LENGTH is not a power of two.
   always_comb begin
      idx_valid = '0;
      for (int unsigned i = 0; i < SPAN; i++)
         idx_valid[i] = (i < LEN_U);
   end

   assign load_ok    = load && idx_valid[load_idx];
   assign first_ok   = dir ? hi_ok : lo_ok;
   assign first_idx  = dir ? hi_idx : lo_idx;
   assign beyond_ok  = dir_q ? dn_ok : up_ok;
   assign beyond_idx = dir_q ? dn_idx : up_idx;
   assign wrap_ok    = lo_ok;
   assign wrap_idx   = dir_q ? hi_idx : lo_idx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         position <= {{(LENGTH-1){1'b0}}, 1'b1};
         state    <= IDLE;
         dir_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wrapped  <= 1'b0;
      end else begin
         wrapped <= 1'b0;
         if (abort) begin
            // Abort decides the state. A valid load in the same cycle still
            // places the line.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            if (load_ok) position <= one_hot(load_idx);
         end else if (load_ok) begin
            position <= one_hot(load_idx);
            if (state == DONE) begin
               state <= IDLE;
               done  <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: if (start) begin
                  dir_q <= dir;
                  if (first_ok) begin
                     position <= one_hot(first_idx);
                     state    <= SCAN;
                     busy     <= 1'b1;
                  end else begin
                     position <= '0;
                     state    <= DONE;
                     done     <= 1'b1;
                  end
               end
               SCAN: if (step) begin
                  if (beyond_ok) begin
                     position <= one_hot(beyond_idx);
                  end else if (WRAP != 0 && wrap_ok) begin
                     position <= one_hot(wrap_idx);
                     wrapped  <= 1'b1;
                  end else begin
                     if (WRAP != 0) position <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
                  done  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
